// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N packet demultiplexer.
// Routes whole packets by first-beat select; bad selects are dropped and counted.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_valid,
  output logic [N_OUT-1:0]        m_last,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [SEL_W:0] NLIM = (SEL_W+1)'(N_OUT);

  state_t                  state;
  logic [SEL_W-1:0]        cur_sel;
  logic [N_OUT*DATA_W-1:0] data_q;
  logic [N_OUT-1:0]        valid_q;
  logic [N_OUT-1:0]        last_q;
  logic [2**SEL_W-1:0]     free;
  logic                    sel_ok;
  logic                    acc;
  logic                    load;
  logic [SEL_W-1:0]        ld_sel;

  // per-slot availability; selects past N_OUT read as free
  always_comb begin
    free = '1;
    free[N_OUT-1:0] = ~valid_q | m_ready;
  end

  assign sel_ok = {1'b0, s_sel} < NLIM;

  // readiness follows the slot the next beat would land in
  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      IDLE:    s_ready = sel_ok ? free[s_sel] : 1'b1;
      ROUTE:   s_ready = free[cur_sel];
      DROP:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign acc    = s_valid && s_ready;
  assign ld_sel = (state == IDLE) ? s_sel : cur_sel;
  assign load   = acc && ((state == IDLE && sel_ok) || state == ROUTE);

  // output slots: load wins over drain so a busy slot never bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (load && ld_sel == SEL_W'(k)) begin
          valid_q[k]                  <= 1'b1;
          last_q[k]                   <= s_last;
          data_q[k*DATA_W +: DATA_W]  <= s_data;
        end else if (m_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // packet FSM with drop counter and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_sel  <= '0;
      drop_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            if (sel_ok) begin
              cur_sel <= s_sel;
              if (!s_last) begin
                state <= ROUTE;
                busy  <= 1'b1;
              end
            end else begin
              if (drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
              if (!s_last) begin
                state <= DROP;
                busy  <= 1'b1;
              end
            end
          end
        end
        ROUTE, DROP: begin
          if (acc && s_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: two instances (4 channels / 3 channels with 2-bit counter)
// checked every cycle against a packet-level model plus literal expectations.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sd   [2];
  logic [1:0] ssel [2];
  logic       sv   [2];
  logic       sl   [2];
  logic [3:0] mrdy;

  logic        a_ready, b_ready;
  logic [31:0] a_data;
  logic [23:0] b_data;
  logic [3:0]  a_valid, a_last;
  logic [2:0]  b_valid, b_last;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;
  logic        a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_data(sd[0]), .s_valid(sv[0]), .s_sel(ssel[0]), .s_last(sl[0]),
    .s_ready(a_ready),
    .m_data(a_data), .m_valid(a_valid), .m_last(a_last), .m_ready(mrdy),
    .drop_cnt(a_cnt), .busy(a_busy)
  );

  stream_demux #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_data(sd[1]), .s_valid(sv[1]), .s_sel(ssel[1]), .s_last(sl[1]),
    .s_ready(b_ready),
    .m_data(b_data), .m_valid(b_valid), .m_last(b_last), .m_ready(mrdy[2:0]),
    .drop_cnt(b_cnt), .busy(b_busy)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int         nout [2] = '{4, 3};
  int         cmax [2] = '{255, 3};
  bit         mv   [2][4];
  logic [7:0] md   [2][4];
  bit         ml   [2][4];
  int         dest [2];
  int         cnt  [2];

  function automatic int target(int i);
    return (dest[i] < 0) ? int'(ssel[i]) : dest[i];
  endfunction

  function automatic bit exp_rdy(int i);
    int t = target(i);
    if (t >= nout[i]) return 1'b1;
    return !mv[i][t] || mrdy[t];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        dest[i] = -1;
        cnt[i] = 0;
        for (int k = 0; k < 4; k++) begin
          mv[i][k] = 1'b0;
          md[i][k] = 8'h00;
          ml[i][k] = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit acc;
        int t;
        acc = sv[i] && exp_rdy(i);
        t = target(i);
        for (int k = 0; k < nout[i]; k++)
          if (mrdy[k]) mv[i][k] = 1'b0;
        if (acc) begin
          if (t < nout[i]) begin
            mv[i][t] = 1'b1;
            md[i][t] = sd[i];
            ml[i][t] = sl[i];
          end else if (dest[i] < 0 && cnt[i] < cmax[i]) begin
            cnt[i]++;
          end
          dest[i] = sl[i] ? -1 : t;
        end
      end
    end
  end

  function automatic logic o_v(int i, int k);
    return (i == 0) ? a_valid[k] : b_valid[k];
  endfunction
  function automatic logic o_l(int i, int k);
    return (i == 0) ? a_last[k] : b_last[k];
  endfunction
  function automatic logic [7:0] o_d(int i, int k);
    return (i == 0) ? a_data[k*8 +: 8] : b_data[k*8 +: 8];
  endfunction

  // every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("a_ready", a_ready, exp_rdy(0));
    chk("b_ready", b_ready, exp_rdy(1));
    chk("a_cnt", a_cnt, cnt[0]);
    chk("b_cnt", b_cnt, cnt[1]);
    chk("a_busy", a_busy, dest[0] >= 0);
    chk("b_busy", b_busy, dest[1] >= 0);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < nout[i]; k++) begin
        chk($sformatf("valid%0d_%0d", i, k), o_v(i, k), mv[i][k]);
        if (mv[i][k]) begin
          chk($sformatf("data%0d_%0d", i, k), o_d(i, k), md[i][k]);
          chk($sformatf("last%0d_%0d", i, k), o_l(i, k), ml[i][k]);
        end
      end
  end

  // transfer log of instance a: {last, data}
  logic [8:0] loga [4][$];

  always @(posedge clk)
    if (rst_n)
      for (int k = 0; k < 4; k++)
        if (a_valid[k] && mrdy[k]) loga[k].push_back({a_last[k], a_data[k*8 +: 8]});

  task automatic clear_logs();
    for (int k = 0; k < 4; k++) loga[k].delete();
  endtask

  task automatic chk_log(string nm, int k, int idx, logic [8:0] exp);
    logic [31:0] act;
    act = (loga[k].size() > idx) ? 32'(loga[k][idx]) : 32'hDEAD;
    chk(nm, act, 32'(exp));
  endtask

  // drives one beat and waits (bounded) until it is accepted
  task automatic send(int i, logic [7:0] d, logic [1:0] sel, logic last);
    logic got;
    got = 1'b0;
    sd[i] = d;
    ssel[i] = sel;
    sl[i] = last;
    sv[i] = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      #3;
      got = (i == 0) ? a_ready : b_ready;
      @(negedge clk);
      #1;
    end
    sv[i] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h on dut %0d never accepted", d, i);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      sd[i] = '0; ssel[i] = '0; sv[i] = 1'b0; sl[i] = 1'b0;
    end
    mrdy = 4'hF;
    #2;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_cnt", b_cnt, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // multi-beat packet, select changes mid-packet
    clear_logs();
    send(0, 8'hA1, 2'd1, 1'b0);
    send(0, 8'hA2, 2'd3, 1'b0);
    send(0, 8'hA3, 2'd3, 1'b1);
    idle(2);
    chk_log("mb_b0", 1, 0, 9'h0A1);
    chk_log("mb_b1", 1, 1, 9'h0A2);
    chk_log("mb_b2", 1, 2, 9'h1A3);
    chk("mb_other", loga[0].size() + loga[2].size() + loga[3].size(), 0);

    // back-pressure on channel 0
    clear_logs();
    mrdy[0] = 1'b0;
    send(0, 8'h10, 2'd0, 1'b0);
    fork
      begin
        send(0, 8'h11, 2'd2, 1'b0);
        send(0, 8'h12, 2'd2, 1'b0);
        send(0, 8'h13, 2'd2, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        #2;
        chk("bp_srdy", a_ready, 0);
        chk("bp_hold", a_data[7:0], 8'h10);
        mrdy[0] = 1'b1;
      end
    join
    idle(3);
    chk_log("bp_b0", 0, 0, 9'h010);
    chk_log("bp_b1", 0, 1, 9'h011);
    chk_log("bp_b2", 0, 2, 9'h012);
    chk_log("bp_b3", 0, 3, 9'h113);
    chk("bp_count", loga[0].size(), 4);

    // independent drain: ch0 stalled, ch2 flows
    clear_logs();
    mrdy[0] = 1'b0;
    send(0, 8'h55, 2'd0, 1'b1);
    send(0, 8'hC1, 2'd2, 1'b0);
    send(0, 8'hC2, 2'd2, 1'b1);
    idle(1);
    chk_log("ind_c1", 2, 0, 9'h0C1);
    chk_log("ind_c2", 2, 1, 9'h1C2);
    chk("ind_hold_v", a_valid[0], 1);
    chk("ind_hold_d", a_data[7:0], 8'h55);
    mrdy[0] = 1'b1;
    idle(2);
    chk_log("ind_c0", 0, 0, 9'h155);

    // drop path on the 3-channel instance
    send(1, 8'hD0, 2'd3, 1'b0);
    chk("drop_cnt1", b_cnt, 1);
    chk("drop_busy", b_busy, 1);
    send(1, 8'hD1, 2'd0, 1'b1);
    chk("drop_cnt1b", b_cnt, 1);
    chk("drop_idle", b_busy, 0);
    send(1, 8'hD2, 2'd3, 1'b1);
    chk("drop_cnt2", b_cnt, 2);
    chk("drop_novalid", b_valid, 0);

    // reset mid-packet
    mrdy[2] = 1'b0;
    send(0, 8'h77, 2'd2, 1'b0);
    chk("mid_busy", a_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_data", a_data, 0);
    chk("arst_bcnt", b_cnt, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mrdy = 4'hF;
    clear_logs();
    send(0, 8'h5A, 2'd2, 1'b1);
    idle(2);
    chk_log("post_rst", 2, 0, 9'h15A);
    chk("post_rst_n", loga[2].size(), 1);

    // counter saturation with CNT_W=2
    for (int n = 0; n < 5; n++) send(1, 8'(n), 2'd3, 1'b1);
    chk("sat_cnt", b_cnt, 3);
    idle(2);
    chk("sat_hold", b_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer: routes whole packets from one valid/ready input stream to one of `N_OUT` output streams, chosen by a select value captured on each packet's first beat. It is the clocked, multi-bit, multi-channel successor to the single-bit combinational demux. It sits between a packet source and per-channel consumers. Packets addressed to a non-existent channel are discarded and counted.

## Interface

Parameters:
- `DATA_W`, 8: payload width per beat.
- `N_OUT`, 4: number of output channels, 2..16.
- `SEL_W`, 2: select width; must satisfy 2^SEL_W >= N_OUT.
- `CNT_W`, 8: width of the dropped-packet counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_W  input payload.
- `s_valid`  in  1  input beat valid.
- `s_sel`  in  SEL_W  destination channel; sampled only on a packet's first beat.
- `s_last`  in  1  marks the final beat of a packet.
- `s_ready`  out  1  input accepts a beat this cycle.
- `m_data`  out  N_OUT*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W].
- `m_valid`  out  N_OUT  per-channel beat valid.
- `m_last`  out  N_OUT  per-channel last flag.
- `m_ready`  in  N_OUT  per-channel consumer ready.
- `drop_cnt`  out  CNT_W  number of dropped packets, saturating.
- `busy`  out  1  high while a packet is in progress (state is not IDLE).

## Operation

- **Handshake.** An input beat is accepted when `s_valid && s_ready`. An output beat on channel k transfers when `m_valid[k] && m_ready[k]`.
- **Output registers.** Each channel has a one-entry output register holding data, last and valid. Slot k is free when `!m_valid[k] || m_ready[k]`.
- **Three-state FSM.**
  - IDLE: no packet in progress.
    - Accepted beat with `s_sel < N_OUT`: load slot `s_sel` and latch `s_sel` into `cur_sel`. Go to ROUTE if `!s_last`, otherwise stay in IDLE.
    - Accepted beat with `s_sel >= N_OUT`: discard the beat. Go to DROP if `!s_last`. Increment `drop_cnt` on this beat whether or not it is also the last beat.
  - ROUTE: every accepted beat is loaded into slot `cur_sel`; `s_sel` is ignored. An accepted beat with `s_last` returns the FSM to IDLE.
  - DROP: every accepted beat is discarded. An accepted beat with `s_last` returns the FSM to IDLE. `drop_cnt` is not incremented again.
- **s_ready (combinational).**
  - IDLE: equals free(`s_sel`) when `s_sel < N_OUT`, else 1.
  - ROUTE: equals free(`cur_sel`).
  - DROP: 1.
- **Combinational paths.** `m_ready` → `s_ready` is allowed. There is no path from `s_valid` to `s_ready`.
- **Non-target channels.** Their registers hold their contents. A channel drains independently whenever its consumer is ready.
- **Drop counter.** `drop_cnt` increments once per dropped packet and saturates at 2^CNT_W−1 with no wrap.
- **Packet ordering.** Packets on one channel leave in arrival order. Packets on different channels have no mutual ordering guarantee.

## Timing

- **Reset.** Asserting `rst_n` low immediately clears all of the following:
  - FSM to IDLE, `cur_sel`=0.
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - `drop_cnt`=0, `busy`=0.
  - `s_ready` then follows the IDLE rule.
- **Reset mid-packet.** The in-flight packet is abandoned, including any beats held in output registers. The first accepted beat after reset is treated as a first beat.
- **Latency.** A beat accepted at edge t appears on `m_*[k]` from t+1. One beat per cycle is sustained when the target consumer holds `m_ready` high.
- **Simultaneous drain and load on the same slot.** The slot takes the new beat and `m_valid` stays high with no bubble.
- **Back-pressure.** While `m_ready[cur_sel]`=0 and the slot is full, `s_ready`=0. The registers hold and no beat is lost or duplicated.
- **Single-beat packet** (first beat with `s_last`=1): routed or dropped, and the FSM never leaves IDLE.
- **`busy`.** Registered; high from the edge after an accepted non-last first beat until the edge that accepts the last beat.

## Test plan

- **Reset values.** Assert `rst_n`=0 mid-stream → all `m_valid`=0, `drop_cnt`=0, `busy`=0 asynchronously, before the next clock edge. After release, a beat with `s_sel`=2 routes to channel 2.
- **Multi-beat routing.** With N_OUT=4, send a 3-beat packet 0xA1,0xA2,0xA3 (`s_last` on 0xA3) with `s_sel`=1 on the first beat, then change `s_sel` to 3 mid-packet, with all `m_ready`=1 → all three beats appear on channel 1 in consecutive cycles, `m_last[1]` is high with 0xA3, and channels 0/2/3 stay invalid.
- **Back-pressure.** Hold `m_ready[0]`=0 during a 4-beat packet to channel 0 → `s_ready` drops after the first beat; release `m_ready[0]` → beats 0x10..0x13 emerge in order with no loss or duplication.
- **Drop path.** With N_OUT=3 and SEL_W=2, send `s_sel`=3 on a 2-beat packet and then a 1-beat packet → `s_ready`=1 throughout, no `m_valid` asserts, and `drop_cnt` goes 0→1→2.
- **Counter saturation.** With CNT_W=2, drop 5 single-beat packets → `drop_cnt` reads 3 and holds.
- **Independent drain.** Queue a beat on channel 0 with `m_ready[0]`=0, then route a packet to channel 2 with `m_ready[2]`=1 → channel 2 data passes unblocked while channel 0 holds its beat.
